// File: rtl/mmcm_phase_shift_sequencer.sv
// mmcm_phase_shift_sequencer
//   Walks the MMCM fine phase shift of SYSCLK_DIV2_PS to an absolute target
//   one PS step at a time, taking the shortest way around the phase circle,
//   and keeps track of the current position. Can also reset the MMCM, which
//   zeroes the tracked position.
//
// Ports
//   phase_control_clk  in   clock, also the generator's PS clock
//   rst                in   asynchronous active-high reset
//   target_pos         in   requested phase 0..PS_PERIOD-1, sampled on go
//   go                 in   strobe: start a move to target_pos (ignored while busy)
//   mmcm_rst_req       in   strobe: reset the MMCM and zero the position (always wins)
//   clr_err            in   clears the sticky err flag
//   mmcm_ctrl          out  [0] PSEN, [1] PSINCDEC, [7] RST, other bits 0
//   mmcm_status        in   [0] PSDONE, other bits ignored
//   cur_pos            out  tracked phase 0..PS_PERIOD-1
//   busy               out  high whenever the sequencer is not idle
//   done               out  one-cycle pulse when a move or reset finishes
//   err                out  sticky: PSDONE timeout or out-of-range target
module mmcm_phase_shift_sequencer #(
    parameter int PS_PERIOD  = 672,
    parameter int POS_WIDTH  = 10,
    parameter int TIMEOUT    = 255,
    parameter int RST_CYCLES = 16
) (
    input  logic                 phase_control_clk,
    input  logic                 rst,
    input  logic [POS_WIDTH-1:0] target_pos,
    input  logic                 go,
    input  logic                 mmcm_rst_req,
    input  logic                 clr_err,
    output logic [7:0]           mmcm_ctrl,
    input  logic [7:0]           mmcm_status,
    output logic [POS_WIDTH-1:0] cur_pos,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAN  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESET = 3'd4;

    localparam logic [POS_WIDTH-1:0] PERIOD_V = POS_WIDTH'(PS_PERIOD);
    localparam logic [POS_WIDTH-1:0] LAST_V   = POS_WIDTH'(PS_PERIOD - 1);
    localparam logic [POS_WIDTH-1:0] HALF_V   = POS_WIDTH'(PS_PERIOD / 2);

    // One down-counter serves both the PSDONE timeout and the RST hold time.
    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [2:0]           state;
    logic [POS_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]     timer;
    logic                 psen;
    logic                 psincdec;
    logic                 mmcm_rst;
    logic                 psdone;
    logic                 status_unused;

    assign psdone        = mmcm_status[0];
    assign status_unused = ^mmcm_status[7:1];
    assign mmcm_ctrl     = {mmcm_rst, 5'b00000, psincdec, psen};

    // Forward distance from a_pos to b_pos around the circle. The true result
    // is always below PS_PERIOD, so wrapping in POS_WIDTH bits is exact.
    function automatic logic [POS_WIDTH-1:0] fwd_dist(
        input logic [POS_WIDTH-1:0] b_pos,
        input logic [POS_WIDTH-1:0] a_pos
    );
        if (b_pos >= a_pos)
            return b_pos - a_pos;
        else
            return b_pos + PERIOD_V - a_pos;
    endfunction

    function automatic logic [POS_WIDTH-1:0] pos_inc(input logic [POS_WIDTH-1:0] p);
        return (p == LAST_V) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [POS_WIDTH-1:0] pos_dec(input logic [POS_WIDTH-1:0] p);
        return (p == '0) ? LAST_V : p - 1'b1;
    endfunction

    always_ff @(posedge phase_control_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_pos   <= '0;
            remaining <= '0;
            timer     <= '0;
            psen      <= 1'b0;
            psincdec  <= 1'b0;
            mmcm_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (clr_err)
                err <= 1'b0;

            if (mmcm_rst_req) begin
                // Aborts anything in flight; re-entering RESET restarts the hold.
                state     <= S_RESET;
                busy      <= 1'b1;
                psen      <= 1'b0;
                psincdec  <= 1'b0;
                mmcm_rst  <= 1'b1;
                cur_pos   <= '0;
                remaining <= '0;
                timer     <= CNT_W'(RST_CYCLES - 1);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go) begin
                            if (target_pos >= PERIOD_V) begin
                                err  <= 1'b1;
                                done <= 1'b1;
                            end else begin
                                remaining <= fwd_dist(target_pos, cur_pos);
                                busy      <= 1'b1;
                                state     <= S_PLAN;
                            end
                        end
                    end

                    // remaining holds the forward distance; convert it to a
                    // step count plus direction, ties going forward.
                    S_PLAN: begin
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            if (remaining > HALF_V) begin
                                psincdec  <= 1'b0;
                                remaining <= PERIOD_V - remaining;
                            end else begin
                                psincdec  <= 1'b1;
                            end
                            psen  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        psen  <= 1'b0;
                        timer <= CNT_W'(TIMEOUT - 1);
                        state <= S_WAIT;
                    end

                    // PSDONE on the last waiting cycle still counts as a step.
                    S_WAIT: begin
                        if (psdone) begin
                            cur_pos   <= psincdec ? pos_inc(cur_pos) : pos_dec(cur_pos);
                            remaining <= remaining - 1'b1;
                            if (remaining == POS_WIDTH'(1)) begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                psincdec <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                psen  <= 1'b1;
                                state <= S_ISSUE;
                            end
                        end else if (timer == '0) begin
                            err      <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            psincdec <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end

                    S_RESET: begin
                        if (timer == '0) begin
                            mmcm_rst <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end

                    default: begin
                        psen     <= 1'b0;
                        psincdec <= 1'b0;
                        mmcm_rst <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
